// File: rtl/spi_cmd_sequencer.sv
// Command FIFO + launch FSM feeding SPI_Master; captures each MISO word into a one-entry response slot.
// Optional watchdog on the WAIT state is compiled in with `define SPI_SEQ_TIMEOUT_EN.
module spi_cmd_sequencer #(
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int TIMEOUT_CYCLES  = 4095
) (
    input  logic                       BOARD_CLOCK,
    input  logic                       RST,
    input  logic [31:0]                CMD_DATA_I,
    input  logic [1:0]                 CMD_SEL_I,
    input  logic                       CMD_WR_I,
    output logic                       CMD_FULL_O,
    output logic [FIFO_DEPTH_LOG2:0]   CMD_LEVEL_O,
    output logic                       CMD_OVF_O,
    output logic [31:0]                RSP_DATA_O,
    output logic [1:0]                 RSP_SEL_O,
    output logic                       RSP_VALID_O,
    input  logic                       RSP_ACK_I,
    output logic                       TIMEOUT_O,
    input  logic                       ERR_CLR_I,
    output logic                       BUSY_O,
    output logic [31:0]                SPI_I_O,
    output logic [1:0]                 SPI_SEL_O,
    output logic                       SPI_START_O,
    input  logic [31:0]                SPI_O_I,
    input  logic                       SPI_DONE_I
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int LW    = FIFO_DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_WAIT} state_t;
    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] data;
    } cmd_t;

    cmd_t                       mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]              level_q, level_d;
    state_t                     state_q, state_d;
    logic [31:0]                spi_i_q, spi_i_d, rsp_data_q, rsp_data_d;
    logic [1:0]                 spi_sel_q, spi_sel_d, rsp_sel_q, rsp_sel_d;
    logic                       start_q, start_d, rsp_valid_q, rsp_valid_d;
    logic                       ovf_q, ovf_d, done_prev_q, done_prev_d;
    logic                       full, push, drop, pop, done_rise;
    cmd_t                       head;

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_q, tmo_d;
`endif

    assign full = (level_q == LW'(DEPTH));
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        push        = CMD_WR_I && (CMD_SEL_I != 2'd3) && !full;
        drop        = CMD_WR_I && !push;
        // A pending ack frees the slot this cycle, so launch without waiting for valid to drop.
        pop         = (state_q == S_IDLE) && (level_q != '0) && (!rsp_valid_q || RSP_ACK_I);
        done_rise   = SPI_DONE_I && !done_prev_q;

        state_d     = state_q;
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d     = level_q;
        if (push && !pop)
            level_d = level_q + LW'(1);
        else if (pop && !push)
            level_d = level_q - LW'(1);
        spi_i_d     = spi_i_q;
        spi_sel_d   = spi_sel_q;
        start_d     = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_sel_d   = rsp_sel_q;
        rsp_valid_d = rsp_valid_q && !RSP_ACK_I;
        done_prev_d = SPI_DONE_I;
        ovf_d       = ERR_CLR_I ? 1'b0 : ovf_q;
        if (drop)
            ovf_d = 1'b1;
`ifdef SPI_SEQ_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        tmo_d       = ERR_CLR_I ? 1'b0 : tmo_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    spi_i_d   = head.data;
                    spi_sel_d = head.sel;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                start_d = 1'b1;
                state_d = S_START;
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef SPI_SEQ_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            default: begin
                if (done_rise) begin
                    rsp_data_d  = SPI_O_I;
                    rsp_sel_d   = spi_sel_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
`ifdef SPI_SEQ_TIMEOUT_EN
                else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
`endif
            end
        endcase
    end

    always_ff @(posedge BOARD_CLOCK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            spi_i_q     <= '0;
            spi_sel_q   <= '0;
            start_q     <= 1'b0;
            rsp_data_q  <= '0;
            rsp_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            done_prev_q <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            tmo_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            spi_i_q     <= spi_i_d;
            spi_sel_q   <= spi_sel_d;
            start_q     <= start_d;
            rsp_data_q  <= rsp_data_d;
            rsp_sel_q   <= rsp_sel_d;
            rsp_valid_q <= rsp_valid_d;
            ovf_q       <= ovf_d;
            done_prev_q <= done_prev_d;
`ifdef SPI_SEQ_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_q       <= tmo_d;
`endif
        end
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge BOARD_CLOCK) begin
        if (push)
            mem_q[wr_ptr_q] <= cmd_t'{sel: CMD_SEL_I, data: CMD_DATA_I};
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    assign TIMEOUT_O = tmo_q;
`else
    logic unused_tmo;
    assign unused_tmo = |TIMEOUT_CYCLES;
    assign TIMEOUT_O  = 1'b0;
`endif

    assign CMD_FULL_O  = full;
    assign CMD_LEVEL_O = level_q;
    assign CMD_OVF_O   = ovf_q;
    assign RSP_DATA_O  = rsp_data_q;
    assign RSP_SEL_O   = rsp_sel_q;
    assign RSP_VALID_O = rsp_valid_q;
    assign BUSY_O      = (state_q != S_IDLE);
    assign SPI_I_O     = spi_i_q;
    assign SPI_SEL_O   = spi_sel_q;
    assign SPI_START_O = start_q;
endmodule
